// File: rtl/sample_capture.sv
// sample_capture: arm-pulsed writer that stores length+1 accepted stream samples into a RAM
// at a stepped, wrapping address. Optional feature macro: CAPTURE_TRIGGER_EN (rising-edge trigger).
module sample_capture #(
  parameter int A_WIDTH = 8,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic [A_WIDTH-1:0] length,
  input  logic [A_WIDTH-1:0] step,
  input  logic [D_WIDTH-1:0] threshold,
  input  logic               s_valid,
  input  logic [D_WIDTH-1:0] s_data,
  output logic               s_ready,
  output logic               wr_en,
  output logic [A_WIDTH-1:0] wr_addr,
  output logic [D_WIDTH-1:0] wr_data,
  output logic               busy,
  output logic               done,
  output logic [A_WIDTH:0]   wr_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [A_WIDTH-1:0] STEP_ONE = {{(A_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [A_WIDTH:0]   CNT_ONE  = {{A_WIDTH{1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic                 wr_en_q, wr_en_d;
  logic [A_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [D_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [A_WIDTH-1:0]   ptr_q, ptr_d;
  logic [A_WIDTH:0]     cnt_q, cnt_d;
  logic [A_WIDTH-1:0]   len_q, len_d;
  logic [A_WIDTH-1:0]   step_q, step_d;
  logic                 accept_s;
  logic                 write_s;
  logic                 last_s;

  assign s_ready  = ((state_q == ARMED) || (state_q == CAPTURE)) && !arm;
  assign accept_s = s_valid && s_ready;
  assign last_s   = (cnt_q == {1'b0, len_q});

`ifdef CAPTURE_TRIGGER_EN
  logic [D_WIDTH-1:0] prev_q, prev_d;
  logic               prev_vld_q, prev_vld_d;
  logic               crossing_s;

  // Samples consumed while waiting are remembered so the next one can be tested for a rising crossing.
  assign crossing_s = prev_vld_q && (prev_q < threshold) && (s_data >= threshold);
  assign write_s    = accept_s && ((state_q == CAPTURE) || crossing_s);

  // Next-state logic for the trigger history.
  always_comb begin
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    if (arm) begin
      prev_vld_d = 1'b0;
    end else if (accept_s && (state_q == ARMED)) begin
      prev_d     = s_data;
      prev_vld_d = 1'b1;
    end else begin
      prev_vld_d = prev_vld_q;
    end
  end

  // Trigger history registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q     <= {D_WIDTH{1'b0}};
      prev_vld_q <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
    end
  end
`else
  logic unused_threshold;
  assign unused_threshold = ^threshold;
  assign write_s          = accept_s;
`endif

  // Capture control: arm restarts, an accepted sample becomes a write one cycle later.
  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    step_d    = step_q;
    if (arm) begin
      state_d = ARMED;
      busy_d  = 1'b1;
      ptr_d   = {A_WIDTH{1'b0}};
      cnt_d   = {(A_WIDTH+1){1'b0}};
      len_d   = length;
      step_d  = (step == {A_WIDTH{1'b0}}) ? STEP_ONE : step;
    end else if (write_s) begin
      wr_en_d   = 1'b1;
      wr_addr_d = ptr_q;
      wr_data_d = s_data;
      ptr_d     = ptr_q + step_q;
      cnt_d     = cnt_q + CNT_ONE;
      if (last_s) begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        state_d = CAPTURE;
        busy_d  = 1'b1;
      end
    end else begin
      case (state_q)
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= {A_WIDTH{1'b0}};
      wr_data_q <= {D_WIDTH{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ptr_q     <= {A_WIDTH{1'b0}};
      cnt_q     <= {(A_WIDTH+1){1'b0}};
      len_q     <= {A_WIDTH{1'b0}};
      step_q    <= STEP_ONE;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      step_q    <= step_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign wr_count = cnt_q;

endmodule

// File: tb/tb_sample_capture.sv
// Bench for sample_capture: a sample-level reference model checked every cycle, plus literal
// write logs per directed scenario. Honours CAPTURE_TRIGGER_EN for the trigger scenario.
module tb_sample_capture;
  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arm = 1'b0;
  logic [AW-1:0] length = 8'd0;
  logic [AW-1:0] step = 8'd0;
  logic [DW-1:0] threshold = 8'd0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = 8'd0;
  logic          s_ready, wr_en, busy, done;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW:0]   wr_count;

  sample_capture #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .arm(arm), .length(length), .step(step), .threshold(threshold),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  bit cmp_en = 1'b0;
  logic [15:0] wlog[$];
  logic [15:0] elog[$];

  task automatic check(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference model: tracks a capture as "how many samples written so far", address = n*step mod depth.
  bit m_busy = 1'b0, m_started = 1'b0, m_have_prev = 1'b0;
  int m_written = 0, m_target = 0, m_step = 1, m_prev = 0;
  bit exp_wr_en = 1'b0, exp_done = 1'b0;
  int exp_addr = 0, exp_data = 0;

  always @(posedge clk) begin
    exp_wr_en = 1'b0;
    exp_done  = 1'b0;
    if (rst) begin
      m_busy = 1'b0; m_written = 0; exp_addr = 0; exp_data = 0; m_have_prev = 1'b0;
    end else if (arm) begin
      m_busy = 1'b1; m_started = 1'b0; m_written = 0; m_have_prev = 1'b0;
      m_target = int'(length) + 1;
      m_step = (step == 8'd0) ? 1 : int'(step);
    end else if (m_busy && s_valid) begin
      bit take;
`ifdef CAPTURE_TRIGGER_EN
      take = m_started || (m_have_prev && (m_prev < int'(threshold)) && (int'(s_data) >= int'(threshold)));
      m_prev = int'(s_data);
      m_have_prev = 1'b1;
`else
      take = 1'b1;
`endif
      if (take) begin
        exp_wr_en = 1'b1;
        exp_addr  = (m_written * m_step) % DEPTH;
        exp_data  = int'(s_data);
        m_written++;
        m_started = 1'b1;
        if (m_written == m_target) begin
          m_busy = 1'b0;
          exp_done = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("s_ready",  longint'(s_ready),  longint'(m_busy && !arm));
      check("wr_en",    longint'(wr_en),    longint'(exp_wr_en));
      check("wr_addr",  longint'(wr_addr),  longint'(exp_addr));
      check("wr_data",  longint'(wr_data),  longint'(exp_data));
      check("busy",     longint'(busy),     longint'(m_busy));
      check("done",     longint'(done),     longint'(exp_done));
      check("wr_count", longint'(wr_count), longint'(m_written));
      if (wr_en) wlog.push_back({wr_addr, wr_data});
      if (done) n_done++;
    end
  end

  task automatic cyc(input bit a, input bit v, input int d);
    arm = a; s_valid = v; s_data = d[7:0];
    @(posedge clk); #1;
  endtask

  task automatic start(input int len, input int stp);
    length = len[7:0]; step = stp[7:0];
    cyc(1'b1, 1'b0, 0);
    arm = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0);
  endtask

  task automatic ew(input int a, input int d);
    elog.push_back({a[7:0], d[7:0]});
  endtask

  task automatic check_log(input string name);
    check({name, "_nwrites"}, longint'(wlog.size()), longint'(elog.size()));
    for (int i = 0; i < elog.size() && i < wlog.size(); i++)
      check({name, "_write"}, longint'(wlog[i]), longint'(elog[i]));
    wlog.delete();
    elog.delete();
  endtask

  initial begin
    rst = 1'b1;
    @(posedge clk); #1;
    cmp_en = 1'b1;
    cyc(1'b0, 1'b1, 99);
    check("reset_wr_count", longint'(wr_count), 0);
    check("reset_s_ready", longint'(s_ready), 0);
    check("reset_wr_en", longint'(wr_en), 0);
    rst = 1'b0;
    idle(2);
    wlog.delete();

    // 1: basic capture; length/step changes while busy must be ignored
    n_done = 0;
    start(3, 1);
    length = 8'd0; step = 8'd7;
    cyc(1'b0, 1'b1, 10); cyc(1'b0, 1'b1, 20); cyc(1'b0, 1'b1, 30); cyc(1'b0, 1'b1, 40);
    idle(3);
    ew(0, 10); ew(1, 20); ew(2, 30); ew(3, 40);
    check_log("t1");
    check("t1_wr_count", longint'(wr_count), 4);
    check("t1_s_ready_after", longint'(s_ready), 0);
    check("t1_done_pulses", longint'(n_done), 1);

    // 2: wrapping step and step==0
    start(3, 128);
    for (int i = 1; i <= 4; i++) cyc(1'b0, 1'b1, i);
    idle(2);
    ew(0, 1); ew(128, 2); ew(0, 3); ew(128, 4);
    check_log("t2_wrap");
    start(3, 0);
    for (int i = 5; i <= 8; i++) cyc(1'b0, 1'b1, i);
    idle(2);
    ew(0, 5); ew(1, 6); ew(2, 7); ew(3, 8);
    check_log("t2_step0");

    // 3: gaps in s_valid
    start(2, 1);
    cyc(1'b0, 1'b1, 11); cyc(1'b0, 1'b0, 12); cyc(1'b0, 1'b0, 13);
    check("t3_addr_hold", longint'(wr_addr), 0);
    check("t3_data_hold", longint'(wr_data), 11);
    cyc(1'b0, 1'b1, 14); cyc(1'b0, 1'b1, 15);
    idle(2);
    ew(0, 11); ew(1, 14); ew(2, 15);
    check_log("t3");

    // 4: re-arm mid-capture with valid high
    start(3, 1);
    cyc(1'b0, 1'b1, 21); cyc(1'b0, 1'b1, 22);
    arm = 1'b1; s_valid = 1'b1; s_data = 8'd23;
    #1 check("t4_ready_on_arm", longint'(s_ready), 0);
    @(posedge clk); #1;
    check("t4_count_restart", longint'(wr_count), 0);
    for (int i = 24; i <= 27; i++) cyc(1'b0, 1'b1, i);
    idle(2);
    ew(0, 21); ew(1, 22); ew(0, 24); ew(1, 25); ew(2, 26); ew(3, 27);
    check_log("t4");
    check("t4_wr_count", longint'(wr_count), 4);

    // 5: reset mid-capture
    start(7, 2);
    cyc(1'b0, 1'b1, 31); cyc(1'b0, 1'b1, 32); cyc(1'b0, 1'b1, 33);
    rst = 1'b1;
    cyc(1'b0, 1'b1, 34);
    rst = 1'b0;
    check("t5_addr_after_rst", longint'(wr_addr), 0);
    check("t5_count_after_rst", longint'(wr_count), 0);
    cyc(1'b0, 1'b1, 35); cyc(1'b0, 1'b1, 36);
    idle(1);
    ew(0, 31); ew(2, 32); ew(4, 33);
    check_log("t5");

    // length==0 and full-range length
    start(0, 5);
    cyc(1'b0, 1'b1, 77);
    check("t7_done_single", longint'(done), 1);
    idle(2);
    ew(0, 77);
    check_log("t7");
    start(255, 1);
    for (int i = 0; i < 256; i++) cyc(1'b0, 1'b1, i);
    check("t8_wr_count_full", longint'(wr_count), 256);
    check("t8_done_full", longint'(done), 1);
    idle(2);
    check("t8_nwrites", longint'(wlog.size()), 256);
    if (wlog.size() == 256) begin
      check("t8_last", longint'(wlog[255]), longint'(16'hFFFF));
      check("t8_first", longint'(wlog[0]), 0);
    end
    wlog.delete();

    // 6: trigger scenario (threshold ignored when the trigger build is off)
    threshold = 8'd100;
    start(1, 1);
    cyc(1'b0, 1'b1, 120); cyc(1'b0, 1'b1, 50); cyc(1'b0, 1'b1, 90);
    cyc(1'b0, 1'b1, 120); cyc(1'b0, 1'b1, 130);
    idle(2);
`ifdef CAPTURE_TRIGGER_EN
    ew(0, 120); ew(1, 130);
`else
    ew(0, 120); ew(1, 50);
`endif
    check_log("t6");
    check("t6_wr_count", longint'(wr_count), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
